// File: rtl/f_op_issuer_pkg.sv
// Shared types for the FPU op issuer: FSM states, the binary64 quiet NaN,
// and the result record carried through the result FIFO.
package f_op_issuer_pkg;

  localparam int RES_W = 64;

  localparam logic [RES_W-1:0] QNAN64 = 64'h7FF8_0000_0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  typedef struct packed {
    logic [RES_W-1:0] res;
    logic             error;
  } result_t;

endpackage

// File: rtl/f_op_result_fifo.sv
// Small synchronous FIFO of result records. The head entry is read straight
// from storage, so it stays put until popped. Pointers wrap mod DEPTH.
import f_op_issuer_pkg::*;

module f_op_result_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  result_t                  push_data_i,
  input  logic                     pop_i,
  output result_t                  head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  result_t        mem_q [DEPTH];
  logic [AW-1:0]  wr_q, rd_q;
  logic [AW:0]    cnt_q, cnt_d;
  logic           push_en, pop_en;

  assign full_o  = (cnt_q == DEPTH_C);
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];

  // Guard against misuse even though the issuer reserves slots upstream.
  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;

  // Occupancy update; push and pop together leave it unchanged.
  always_comb begin
    cnt_d = cnt_q;
    case ({push_en, pop_en})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage, pointers and count; reset flushes everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_en) begin
        mem_q[wr_q] <= push_data_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop_en) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/f_op_issuer.sv
// Issues operand pairs one at a time to an iterative FPU and queues each
// result with its error flag for a valid/ready consumer.
// Optional watchdog: define F_OP_ISSUER_TIMEOUT_EN to abandon an op after
// TIMEOUT cycles in WAIT and return a quiet NaN with error set.
import f_op_issuer_pkg::*;

module f_op_issuer #(
  parameter int FLEN    = 64,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 256
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [FLEN-1:0] req_a,
  input  logic [FLEN-1:0] req_b,
  output logic [FLEN-1:0] fpu_a,
  output logic [FLEN-1:0] fpu_b,
  output logic            fpu_up_valid,
  input  logic            fpu_busy,
  input  logic            fpu_down_valid,
  input  logic [FLEN-1:0] fpu_res,
  input  logic            fpu_error,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [FLEN-1:0] rsp_res,
  output logic            rsp_error
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  state_t          state_q, state_d;
  logic [FLEN-1:0] a_q, b_q;
  logic            accept;
  logic            push;
  result_t         push_data;
  result_t         head;
  logic            empty;
  logic [CW-1:0]   count;

`ifdef F_OP_ISSUER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wd_q, wd_d;
  logic          wd_expired;
  assign wd_expired = (wd_q == TW'(TIMEOUT - 1));
`endif

  // Handshake happens only in IDLE; count is the registered occupancy, so a
  // same-cycle pop never opens a slot combinationally.
  assign accept = req_valid && req_ready;

  // Next state, handshake outputs and FIFO push.
  always_comb begin
    state_d      = state_q;
    req_ready    = 1'b0;
    fpu_up_valid = 1'b0;
    push         = 1'b0;
    push_data    = '{res: fpu_res, error: fpu_error};
    case (state_q)
      IDLE: begin
        req_ready = !rst && !fpu_busy && (count < DEPTH_C);
        if (req_valid && req_ready) state_d = ISSUE;
      end
      ISSUE: begin
        fpu_up_valid = 1'b1;
        state_d      = WAIT;
      end
      WAIT: begin
        if (fpu_down_valid) begin
          push    = 1'b1;
          state_d = IDLE;
        end
`ifdef F_OP_ISSUER_TIMEOUT_EN
        else if (wd_expired) begin
          push      = 1'b1;
          push_data = '{res: QNAN64, error: 1'b1};
          state_d   = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Operand registers: loaded on accept, held through ISSUE and WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else if (accept) begin
      a_q <= req_a;
      b_q <= req_b;
    end
  end

  assign fpu_a = a_q;
  assign fpu_b = b_q;

`ifdef F_OP_ISSUER_TIMEOUT_EN
  // Watchdog counts WAIT cycles and restarts whenever WAIT is left.
  always_comb begin
    wd_d = '0;
    if (state_q == WAIT && state_d == WAIT) wd_d = wd_q + 1'b1;
  end

  // Watchdog register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wd_q <= '0;
    else     wd_q <= wd_d;
  end
`endif

  f_op_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (rsp_valid && rsp_ready),
    .head_o      (head),
    .full_o      (),
    .empty_o     (empty),
    .count_o     (count)
  );

  assign rsp_valid = !empty;
  assign rsp_res   = head.res;
  assign rsp_error = head.error;

endmodule

// File: tb/tb_f_op_issuer.sv
// Bench for f_op_issuer: behavioural sqrt FPU stub, request driver,
// consumer with selectable backpressure, and a queue-based reference.
module tb_f_op_issuer;

  localparam int FLEN = 64, DEPTH = 4, TIMEOUT = 16;
  localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

  logic clk = 1'b0;
  logic rst;
  logic req_valid, req_ready;
  logic [63:0] req_a, req_b, fpu_a, fpu_b, fpu_res, rsp_res;
  logic fpu_up_valid, fpu_busy, fpu_down_valid, fpu_error;
  logic rsp_valid, rsp_ready, rsp_error;

  always #5 clk = ~clk;

  f_op_issuer #(.FLEN(FLEN), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_up_valid(fpu_up_valid), .fpu_busy(fpu_busy),
    .fpu_down_valid(fpu_down_valid), .fpu_res(fpu_res), .fpu_error(fpu_error),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_res(rsp_res), .rsp_error(rsp_error)
  );

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Square root as an f_sqrt wrapper would report it: {error, result}.
  function automatic logic [64:0] sqrt_ref(input logic [63:0] a);
    if (a[63] && a[62:0] != 63'd0) return {1'b1, QNAN};
    if (a[62:0] == 63'd0)          return {1'b0, a};
    return {1'b0, $realtobits($sqrt($bitstoreal(a)))};
  endfunction

  function automatic logic [63:0] rand_op(input bit allow_neg);
    logic [63:0] v;
    v = $realtobits(real'($urandom_range(0, 1000000)) / 64.0);
    if (allow_neg && $urandom_range(0, 3) == 0 && v != 64'd0) v[63] = 1'b1;
    return v;
  endfunction

  // ---------------- FPU stub ----------------
  logic stub_hang = 1'b0, force_dv = 1'b0;
  logic [63:0] force_res = '0;
  int st_cnt;
  logic st_busy, st_dv, st_err;
  logic [63:0] st_res, st_a;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      st_busy <= 1'b0; st_dv <= 1'b0; st_cnt <= 0;
      st_res <= '0; st_err <= 1'b0; st_a <= '0;
    end else begin
      st_dv <= 1'b0;
      if (fpu_up_valid) begin
        st_busy <= 1'b1;
        st_cnt  <= $urandom_range(1, 5);
        st_a    <= fpu_a;
      end else if (st_busy && !stub_hang) begin
        if (st_cnt <= 1) begin
          st_busy <= 1'b0;
          st_dv   <= 1'b1;
          {st_err, st_res} <= sqrt_ref(st_a);
        end else st_cnt <= st_cnt - 1;
      end
    end
  end

  assign fpu_busy       = st_busy;
  assign fpu_down_valid = st_dv | force_dv;
  assign fpu_res        = force_dv ? force_res : st_res;
  assign fpu_error      = force_dv ? 1'b0 : st_err;

  // ---------------- request driver ----------------
  typedef struct { logic [63:0] a; logic [63:0] b; } req_t;
  req_t req_q[$];
  req_t iss_q[$];
  logic [64:0] exp_q[$];
  bit exp_timeout = 0;

  initial begin
    bit took;
    req_valid = 1'b0; req_a = '0; req_b = '0;
    forever begin
      @(negedge clk);
      took = req_valid && req_ready;
      @(posedge clk); #1;
      if (took && req_q.size() > 0) req_q.delete(0);
      if (req_q.size() > 0 && !rst) begin
        req_valid = 1'b1; req_a = req_q[0].a; req_b = req_q[0].b;
      end else req_valid = 1'b0;
    end
  end

  // ---------------- consumer ----------------
  int rdy_mode = 0; // 0 stall, 1 always ready, 2 random
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       rsp_ready = 1'b0;
        1:       rsp_ready = 1'b1;
        default: rsp_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  bit prev_acc = 0, prev_upv = 0, prev_hold = 0;
  logic [63:0] hold_res, cur_a, cur_b, last_res;
  logic hold_err, last_err;
  int n_pop = 0;

  always @(negedge clk) begin
    bit acc;
    if (rst) begin
      prev_acc = 0; prev_upv = 0; prev_hold = 0;
    end else begin
      if (prev_acc || fpu_up_valid) chk("issue_lat", 64'(fpu_up_valid), 64'(prev_acc));
      if (fpu_up_valid) begin
        chk("upv_while_busy", 64'(fpu_busy), 64'd0);
        chk("upv_pulse", 64'(prev_upv), 64'd0);
        if (iss_q.size() == 0) chk("issue_unexpected", 64'd1, 64'd0);
        else begin
          chk("fpu_a", fpu_a, iss_q[0].a);
          chk("fpu_b", fpu_b, iss_q[0].b);
          cur_a = iss_q[0].a; cur_b = iss_q[0].b;
          iss_q.delete(0);
        end
      end else if (fpu_busy) begin
        chk("fpu_a_stable", fpu_a, cur_a);
        chk("fpu_b_stable", fpu_b, cur_b);
      end
      acc = req_valid && req_ready;
      if (acc) begin
        iss_q.push_back('{a: req_a, b: req_b});
        exp_q.push_back(exp_timeout ? {1'b1, QNAN} : sqrt_ref(req_a));
      end
      if (prev_hold) begin
        chk("rsp_hold_valid", 64'(rsp_valid), 64'd1);
        chk("rsp_hold_res", rsp_res, hold_res);
        chk("rsp_hold_err", 64'(rsp_error), 64'(hold_err));
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) chk("rsp_unexpected", 64'd1, 64'd0);
        else begin
          chk("rsp_res", rsp_res, exp_q[0][63:0]);
          chk("rsp_err", 64'(rsp_error), 64'(exp_q[0][64]));
          exp_q.delete(0);
        end
        last_res = rsp_res; last_err = rsp_error; n_pop++;
      end
      prev_hold = rsp_valid && !rsp_ready;
      hold_res  = rsp_res; hold_err = rsp_error;
      prev_acc  = acc;
      prev_upv  = fpu_up_valid;
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((req_q.size() != 0 || exp_q.size() != 0 || iss_q.size() != 0 || fpu_busy) && n < 2000) begin
      tick(); n++;
    end
    if (n >= 2000) chk({tag, "_drain_timeout"}, 64'd1, 64'd0);
  endtask

  // ---------------- sequence ----------------
  initial begin
    int p0, n;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    tick();
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_up_valid", 64'(fpu_up_valid), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_fpu_a", fpu_a, 64'd0);
    chk("rst_fpu_b", fpu_b, 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    tick();
    chk("idle_req_ready", 64'(req_ready), 64'd1);

    // sqrt(4.0)
    rdy_mode = 1;
    req_q.push_back('{a: 64'h4010_0000_0000_0000, b: 64'h1234});
    wait_drain("t1");
    chk("t1_res", last_res, 64'h4000_0000_0000_0000);
    chk("t1_err", 64'(last_err), 64'd0);

    // sqrt(-1.0)
    req_q.push_back('{a: 64'hBFF0_0000_0000_0000, b: 64'h0});
    wait_drain("t2");
    chk("t2_res", last_res, QNAN);
    chk("t2_err", 64'(last_err), 64'd1);

    // Backpressure: fill the FIFO, two requests left waiting.
    rdy_mode = 0;
    p0 = n_pop;
    for (int i = 0; i < 6; i++) req_q.push_back('{a: rand_op(0), b: {$urandom, $urandom}});
    repeat (80) tick();
    chk("bp_req_ready", 64'(req_ready), 64'd0);
    chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("bp_queued", 64'(exp_q.size()), 64'd4);
    chk("bp_pending", 64'(req_q.size()), 64'd2);
    rdy_mode = 1;
    wait_drain("t3");
    chk("bp_pops", 64'(n_pop - p0), 64'd6);

    // Randomised traffic with random backpressure.
    rdy_mode = 2;
    p0 = n_pop;
    for (int i = 0; i < 40; i++) req_q.push_back('{a: rand_op(1), b: {$urandom, $urandom}});
    wait_drain("t4");
    chk("rand_pops", 64'(n_pop - p0), 64'd40);

    // Reset while waiting on the FPU, then a stale down_valid.
    rdy_mode = 1;
    stub_hang = 1'b1;
    req_q.push_back('{a: rand_op(0), b: 64'h55});
    n = 0;
    while (!fpu_busy && n < 100) begin tick(); n++; end
    chk("t5_reach_wait", 64'(fpu_busy), 64'd1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete(); iss_q.delete(); req_q.delete();
    stub_hang = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    force_dv = 1'b1; force_res = {$urandom, $urandom};
    @(posedge clk); #1 force_dv = 1'b0;
    tick();
    chk("t5_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("t5_req_ready", 64'(req_ready), 64'd1);
    repeat (5) tick();
    chk("t5_rsp_valid_later", 64'(rsp_valid), 64'd0);

`ifdef F_OP_ISSUER_TIMEOUT_EN
    // Watchdog: the stub never answers.
    rdy_mode = 0;
    stub_hang = 1'b1;
    exp_timeout = 1;
    req_q.push_back('{a: 64'h4010_0000_0000_0000, b: 64'h0});
    n = 0;
    while (!fpu_up_valid && n < 100) begin tick(); n++; end
    chk("t6_issued", 64'(fpu_up_valid), 64'd1);
    n = 0;
    while (!rsp_valid && n < 100) begin tick(); n++; end
    chk("t6_latency", 64'(n), 64'd17);
    chk("t6_res", rsp_res, QNAN);
    chk("t6_err", 64'(rsp_error), 64'd1);
    exp_timeout = 0;
    rdy_mode = 1;
    stub_hang = 1'b0;
    repeat (20) tick();
    chk("t6_late_dropped", 64'(rsp_valid), 64'd0);
    chk("t6_queue_empty", 64'(exp_q.size()), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
